// File: rtl/expansor_vizinhos_pkg.sv
// Shared definitions for the neighbour-expansion block.
//  - estado_t      : expansion FSM states
//  - DIST_INFINITA : all-ones distance ("unreachable"), sliced to width by users
//  - field helpers : bit offsets of {valido, vizinho, custo, menor_vizinho}
//                    inside a graph RAM word
package expansor_vizinhos_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LER    = 3'd1,
    ESPERA = 3'd2,
    EMITIR = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam logic [31:0] DIST_INFINITA = '1;

  // Graph RAM word layout, MSB to LSB: valido | vizinho | custo | menor_vizinho
  function automatic int unsigned menor_lsb();
    return 0;
  endfunction

  function automatic int unsigned custo_lsb(input int unsigned custo_w);
    return custo_w;
  endfunction

  function automatic int unsigned vizinho_lsb(input int unsigned custo_w);
    return 2 * custo_w;
  endfunction

  function automatic int unsigned valido_bit(input int unsigned addr_w,
                                             input int unsigned custo_w);
    return addr_w + 2 * custo_w;
  endfunction

endpackage

// File: rtl/expansor_vizinhos_somador.sv
// somador_distancia: combinational accumulated-distance adder.
//  i_distancia : settled distance of the expanded node
//  i_custo     : edge cost (zero-extended)
//  o_soma      : i_distancia + i_custo
// Build option EXPANSOR_SATURACAO_EN: on carry out the result saturates to
// DIST_INFINITA; otherwise the low DISTANCIA_WIDTH bits are kept (wrap).
module somador_distancia
  import expansor_vizinhos_pkg::*;
#(
  parameter int unsigned DISTANCIA_WIDTH = 5,
  parameter int unsigned CUSTO_WIDTH     = 4
) (
  input  logic [DISTANCIA_WIDTH-1:0] i_distancia,
  input  logic [CUSTO_WIDTH-1:0]     i_custo,
  output logic [DISTANCIA_WIDTH-1:0] o_soma
);

`ifdef EXPANSOR_SATURACAO_EN
  localparam bit SATURA = 1'b1;
`else
  localparam bit SATURA = 1'b0;
`endif

  logic [DISTANCIA_WIDTH:0] w_soma_ext;

  always_comb begin
    w_soma_ext = {1'b0, i_distancia} + (DISTANCIA_WIDTH+1)'(i_custo);
    if (SATURA && w_soma_ext[DISTANCIA_WIDTH])
      o_soma = DIST_INFINITA[DISTANCIA_WIDTH-1:0];
    else
      o_soma = w_soma_ext[DISTANCIA_WIDTH-1:0];
  end

endmodule

// File: rtl/expansor_vizinhos.sv
// expansor_vizinhos: walks the adjacency list of a just-closed node and emits
// one update beat per valid neighbour towards the active-node allocator.
//  clk, rst_n           : clock, asynchronous active-low reset
//  start_in             : start expansion (sampled only in IDLE)
//  no_in, distancia_in  : node to expand and its settled distance
//  mem_addr_out/rd_out  : graph RAM read port, address {no, slot}
//  mem_data_in          : {valido, vizinho, custo, menor_vizinho}, 1 cycle latency
//  atualizar_out/aceito_in : update beat valid/accept handshake
//  endereco_out, anterior_out, distancia_out, menor_vizinho_out : beat payload
//  ocupado_out          : FSM busy
//  pronto_out           : 1-cycle pulse when the list is finished
// Build option EXPANSOR_SATURACAO_EN selects saturating distance sums.
module expansor_vizinhos
  import expansor_vizinhos_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 5,
  parameter int unsigned CUSTO_WIDTH     = 4,
  parameter int unsigned VIZ_WIDTH       = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_in,
  input  logic [ADDR_WIDTH-1:0]              no_in,
  input  logic [DISTANCIA_WIDTH-1:0]         distancia_in,
  output logic [ADDR_WIDTH+VIZ_WIDTH-1:0]    mem_addr_out,
  output logic                               mem_rd_out,
  input  logic [ADDR_WIDTH+2*CUSTO_WIDTH:0]  mem_data_in,
  input  logic                               aceito_in,
  output logic                               atualizar_out,
  output logic [ADDR_WIDTH-1:0]              endereco_out,
  output logic [ADDR_WIDTH-1:0]              anterior_out,
  output logic [DISTANCIA_WIDTH-1:0]         distancia_out,
  output logic [CUSTO_WIDTH-1:0]             menor_vizinho_out,
  output logic                               ocupado_out,
  output logic                               pronto_out
);

  localparam int unsigned VALIDO_BIT  = valido_bit(ADDR_WIDTH, CUSTO_WIDTH);
  localparam int unsigned VIZINHO_LSB = vizinho_lsb(CUSTO_WIDTH);
  localparam int unsigned CUSTO_LSB   = custo_lsb(CUSTO_WIDTH);
  localparam int unsigned MENOR_LSB   = menor_lsb();

  estado_t                      r_estado;
  logic [ADDR_WIDTH-1:0]        r_no;
  logic [DISTANCIA_WIDTH-1:0]   r_dist;
  logic [VIZ_WIDTH-1:0]         r_slot;

  logic                         w_valido;
  logic [ADDR_WIDTH-1:0]        w_vizinho;
  logic [CUSTO_WIDTH-1:0]       w_custo;
  logic [CUSTO_WIDTH-1:0]       w_menor;
  logic [DISTANCIA_WIDTH-1:0]   w_soma;
  logic                         w_ultimo;
  logic [VIZ_WIDTH-1:0]         w_slot_prox;

  assign w_valido    = mem_data_in[VALIDO_BIT];
  assign w_vizinho   = mem_data_in[VIZINHO_LSB +: ADDR_WIDTH];
  assign w_custo     = mem_data_in[CUSTO_LSB +: CUSTO_WIDTH];
  assign w_menor     = mem_data_in[MENOR_LSB +: CUSTO_WIDTH];
  // Termination compares against the last slot so the counter never wraps.
  assign w_ultimo    = (r_slot == '1);
  assign w_slot_prox = r_slot + VIZ_WIDTH'(1);

  somador_distancia #(
    .DISTANCIA_WIDTH (DISTANCIA_WIDTH),
    .CUSTO_WIDTH     (CUSTO_WIDTH)
  ) u_somador (
    .i_distancia (r_dist),
    .i_custo     (w_custo),
    .o_soma      (w_soma)
  );

  // The RAM read strobe and address are registered on entry to LER so the
  // read is issued during the LER cycle and data is sampled at the end of ESPERA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado          <= IDLE;
      r_no              <= '0;
      r_dist            <= '0;
      r_slot            <= '0;
      mem_addr_out      <= '0;
      mem_rd_out        <= 1'b0;
      atualizar_out     <= 1'b0;
      endereco_out      <= '1;
      anterior_out      <= '1;
      distancia_out     <= '0;
      menor_vizinho_out <= '0;
      ocupado_out       <= 1'b0;
      pronto_out        <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (start_in) begin
            r_no         <= no_in;
            r_dist       <= distancia_in;
            r_slot       <= '0;
            mem_addr_out <= {no_in, {VIZ_WIDTH{1'b0}}};
            mem_rd_out   <= 1'b1;
            ocupado_out  <= 1'b1;
            r_estado     <= LER;
          end
        end
        LER: begin
          mem_rd_out <= 1'b0;
          r_estado   <= ESPERA;
        end
        ESPERA: begin
          if (w_valido) begin
            endereco_out      <= w_vizinho;
            anterior_out      <= r_no;
            distancia_out     <= w_soma;
            menor_vizinho_out <= w_menor;
            atualizar_out     <= 1'b1;
            r_estado          <= EMITIR;
          end else begin
            pronto_out <= 1'b1;
            r_estado   <= FIM;
          end
        end
        EMITIR: begin
          // atualizar_out is always high here, so aceito_in alone completes the beat.
          if (aceito_in) begin
            atualizar_out <= 1'b0;
            if (w_ultimo) begin
              pronto_out <= 1'b1;
              r_estado   <= FIM;
            end else begin
              r_slot       <= w_slot_prox;
              mem_addr_out <= {r_no, w_slot_prox};
              mem_rd_out   <= 1'b1;
              r_estado     <= LER;
            end
          end
        end
        FIM: begin
          pronto_out  <= 1'b0;
          ocupado_out <= 1'b0;
          r_estado    <= IDLE;
        end
        default: begin
          r_estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expansor_vizinhos.sv
module tb_expansor_vizinhos;

  localparam int AW = 5;
  localparam int DW = 5;
  localparam int CW = 4;
  localparam int VW = 2;
  localparam int MW = 1 + AW + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_in;
  logic [AW-1:0] no_in;
  logic [DW-1:0] distancia_in;
  logic [AW+VW-1:0] mem_addr_out;
  logic          mem_rd_out;
  logic [MW-1:0] mem_data_in;
  logic          aceito_in;
  logic          atualizar_out;
  logic [AW-1:0] endereco_out;
  logic [AW-1:0] anterior_out;
  logic [DW-1:0] distancia_out;
  logic [CW-1:0] menor_vizinho_out;
  logic          ocupado_out;
  logic          pronto_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  expansor_vizinhos #(
    .ADDR_WIDTH      (AW),
    .DISTANCIA_WIDTH (DW),
    .CUSTO_WIDTH     (CW),
    .VIZ_WIDTH       (VW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_in          (start_in),
    .no_in             (no_in),
    .distancia_in      (distancia_in),
    .mem_addr_out      (mem_addr_out),
    .mem_rd_out        (mem_rd_out),
    .mem_data_in       (mem_data_in),
    .aceito_in         (aceito_in),
    .atualizar_out     (atualizar_out),
    .endereco_out      (endereco_out),
    .anterior_out      (anterior_out),
    .distancia_out     (distancia_out),
    .menor_vizinho_out (menor_vizinho_out),
    .ocupado_out       (ocupado_out),
    .pronto_out        (pronto_out)
  );

  // Graph RAM model: one-cycle read latency
  logic [MW-1:0] mem [0:(1<<(AW+VW))-1];
  always @(posedge clk) if (mem_rd_out) mem_data_in <= mem[mem_addr_out];

  // Activity log sampled on the falling edge
  logic [AW-1:0]    q_end[$];
  logic [AW-1:0]    q_ant[$];
  logic [DW-1:0]    q_dist[$];
  logic [CW-1:0]    q_menor[$];
  logic [AW+VW-1:0] q_addr[$];
  int               n_pronto = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (atualizar_out && aceito_in) begin
        q_end.push_back(endereco_out);
        q_ant.push_back(anterior_out);
        q_dist.push_back(distancia_out);
        q_menor.push_back(menor_vizinho_out);
      end
      if (mem_rd_out) q_addr.push_back(mem_addr_out);
      if (pronto_out) n_pronto++;
    end
  end

  function automatic logic [MW-1:0] ent(input bit v, input logic [AW-1:0] viz,
                                        input logic [CW-1:0] c, input logic [CW-1:0] m);
    return {v, viz, c, m};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < (1 << (AW + VW)); i++) mem[i] = '0;
    q_end.delete(); q_ant.delete(); q_dist.delete(); q_menor.delete(); q_addr.delete();
    n_pronto = 0;
  endtask

  task automatic set_entry(input logic [AW-1:0] no, input logic [VW-1:0] slot,
                           input logic [MW-1:0] val);
    mem[{no, slot}] = val;
  endtask

  // Returns after the edge that samples start_in (in IDLE)
  task automatic do_start(input logic [AW-1:0] no, input logic [DW-1:0] d);
    @(posedge clk); #1;
    start_in = 1'b1; no_in = no; distancia_in = d;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_pronto(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (pronto_out) begin n = i; break; end
    end
  endtask

  task automatic wait_beat(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (atualizar_out) begin n = i; break; end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_two_neighbours();
    set_entry(5'd3, 2'd0, ent(1'b1, 5'd7, 4'd2, 4'd1));
    set_entry(5'd3, 2'd1, ent(1'b1, 5'd9, 4'd5, 4'd4));
    set_entry(5'd3, 2'd2, ent(1'b0, 5'd0, 4'd0, 4'd0));
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; start_in = 1'b0; no_in = '0; distancia_in = '0; aceito_in = 1'b0;
    clear_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({atualizar_out, ocupado_out, pronto_out, mem_rd_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got atu/ocu/pro/rd=%b want 0000",
               {atualizar_out, ocupado_out, pronto_out, mem_rd_out});
    end
    checks++;
    if ({endereco_out, anterior_out, distancia_out, menor_vizinho_out} !== {5'h1F, 5'h1F, 5'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_data got end=%h ant=%h dist=%0d menor=%0d want 1f 1f 0 0",
               endereco_out, anterior_out, distancia_out, menor_vizinho_out);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Abort mid-EMITIR
    load_two_neighbours();
    do_start(5'd3, 5'd4);
    wait_beat(20, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL reset_first_beat_latency got %0d want 3", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({atualizar_out, ocupado_out, endereco_out} !== {1'b0, 1'b0, 5'h1F}) begin
      errors++;
      $display("FAIL reset_abort got atu=%b ocu=%b end=%h want 0 0 1f",
               atualizar_out, ocupado_out, endereco_out);
    end
    @(posedge clk); #1 rst_n = 1'b1; aceito_in = 1'b1;
    q_end.delete(); q_ant.delete(); q_dist.delete(); q_menor.delete(); q_addr.delete();
    n_pronto = 0;
    do_start(5'd3, 5'd4);
    wait_pronto(40, n);
    idle_cycles(3);
    checks++;
    if (n < 0 || q_end.size() != 2) begin
      errors++;
      $display("FAIL reset_restart got pronto_at=%0d beats=%0d want pronto and 2 beats", n, q_end.size());
    end else begin
      checks++;
      if ({q_end[0], q_ant[0], q_dist[0]} !== {5'd7, 5'd3, 5'd6}) begin
        errors++;
        $display("FAIL reset_restart_beat got (%0d,%0d,%0d) want (7,3,6)", q_end[0], q_ant[0], q_dist[0]);
      end
    end
  endtask

  task automatic test_two_neighbours();
    int n;
    clear_all();
    load_two_neighbours();
    aceito_in = 1'b1;
    do_start(5'd3, 5'd4);
    wait_pronto(40, n);
    idle_cycles(5);
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL two_pronto_latency got %0d want 9", n);
    end
    checks++;
    if (q_end.size() != 2) begin
      errors++;
      $display("FAIL two_beat_count got %0d want 2", q_end.size());
    end else begin
      checks++;
      if ({q_end[0], q_ant[0], q_dist[0], q_menor[0]} !== {5'd7, 5'd3, 5'd6, 4'd1}) begin
        errors++;
        $display("FAIL two_beat0 got (%0d,%0d,%0d,%0d) want (7,3,6,1)",
                 q_end[0], q_ant[0], q_dist[0], q_menor[0]);
      end
      checks++;
      if ({q_end[1], q_ant[1], q_dist[1], q_menor[1]} !== {5'd9, 5'd3, 5'd9, 4'd4}) begin
        errors++;
        $display("FAIL two_beat1 got (%0d,%0d,%0d,%0d) want (9,3,9,4)",
                 q_end[1], q_ant[1], q_dist[1], q_menor[1]);
      end
    end
    checks++;
    if (n_pronto != 1 || ocupado_out !== 1'b0) begin
      errors++;
      $display("FAIL two_end got pronto_pulses=%0d ocupado=%b want 1 0", n_pronto, ocupado_out);
    end
  endtask

  task automatic test_back_to_back_hold();
    int n;
    logic [AW+AW+DW+CW-1:0] snap;
    clear_all();
    load_two_neighbours();
    aceito_in = 1'b0;
    do_start(5'd3, 5'd4);
    wait_beat(20, n);
    snap = {endereco_out, anterior_out, distancia_out, menor_vizinho_out};
    checks++;
    if (n != 3 || snap !== {5'd7, 5'd3, 5'd6, 4'd1}) begin
      errors++;
      $display("FAIL hold_first got at=%0d payload=%h want 3 %h", n, snap, {5'd7, 5'd3, 5'd6, 4'd1});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (!atualizar_out || {endereco_out, anterior_out, distancia_out, menor_vizinho_out} !== snap) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got atu=%b payload=%h want 1 %h", k, atualizar_out,
                 {endereco_out, anterior_out, distancia_out, menor_vizinho_out}, snap);
      end
    end
    @(posedge clk); #1 aceito_in = 1'b1;
    wait_pronto(40, n);
    idle_cycles(3);
    checks++;
    if (q_end.size() != 2) begin
      errors++;
      $display("FAIL hold_beat_count got %0d want 2", q_end.size());
    end else begin
      checks++;
      if ({q_end[0], q_dist[0], q_end[1], q_dist[1]} !== {5'd7, 5'd6, 5'd9, 5'd9}) begin
        errors++;
        $display("FAIL hold_beats got (%0d,%0d)(%0d,%0d) want (7,6)(9,9)",
                 q_end[0], q_dist[0], q_end[1], q_dist[1]);
      end
    end
  endtask

  task automatic test_four_slots();
    int n;
    clear_all();
    for (int s = 0; s < 4; s++)
      set_entry(5'd5, VW'(s), ent(1'b1, AW'(10 + s), CW'(1 + s), CW'(s)));
    aceito_in = 1'b1;
    do_start(5'd5, 5'd1);
    wait_pronto(60, n);
    idle_cycles(6);
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL four_pronto_latency got %0d want 13", n);
    end
    checks++;
    if (q_addr.size() != 4) begin
      errors++;
      $display("FAIL four_read_count got %0d want 4", q_addr.size());
    end else begin
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (q_addr[s] !== 7'(20 + s)) begin
          errors++;
          $display("FAIL four_addr slot %0d got %0d want %0d", s, q_addr[s], 20 + s);
        end
      end
    end
    checks++;
    if (q_end.size() != 4) begin
      errors++;
      $display("FAIL four_beat_count got %0d want 4", q_end.size());
    end else begin
      for (int s = 0; s < 4; s++) begin
        checks++;
        if ({q_end[s], q_ant[s], q_dist[s], q_menor[s]} !== {AW'(10 + s), 5'd5, DW'(2 + s), CW'(s)}) begin
          errors++;
          $display("FAIL four_beat %0d got (%0d,%0d,%0d,%0d) want (%0d,5,%0d,%0d)", s,
                   q_end[s], q_ant[s], q_dist[s], q_menor[s], 10 + s, 2 + s, s);
        end
      end
    end
    checks++;
    if (n_pronto != 1) begin
      errors++;
      $display("FAIL four_pronto_pulses got %0d want 1", n_pronto);
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [DW-1:0] esperado;
`ifdef EXPANSOR_SATURACAO_EN
    esperado = 5'd31;
`else
    esperado = 5'd3;
`endif
    clear_all();
    set_entry(5'd2, 2'd0, ent(1'b1, 5'd4, 4'd5, 4'd0));
    aceito_in = 1'b1;
    do_start(5'd2, 5'd30);
    wait_pronto(30, n);
    idle_cycles(2);
    checks++;
    if (q_dist.size() != 1) begin
      errors++;
      $display("FAIL overflow_beat_count got %0d want 1", q_dist.size());
    end else begin
      checks++;
      if (q_dist[0] !== esperado) begin
        errors++;
        $display("FAIL overflow_dist got %0d want %0d", q_dist[0], esperado);
      end
    end
  endtask

  task automatic test_empty_list();
    int n;
    bit viu_atualizar;
    clear_all();
    set_entry(5'd8, 2'd0, ent(1'b0, 5'd1, 4'd1, 4'd1));
    aceito_in = 1'b1;
    viu_atualizar = 1'b0;
    n = -1;
    do_start(5'd8, 5'd0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (atualizar_out) viu_atualizar = 1'b1;
      if (pronto_out && n < 0) n = i;
      // start_in raised while busy must be ignored
      if (i == 1) begin start_in = 1'b1; no_in = 5'd3; distancia_in = 5'd2; end
      if (i == 2) start_in = 1'b0;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL empty_pronto_latency got %0d want 3", n);
    end
    checks++;
    if (viu_atualizar || q_end.size() != 0) begin
      errors++;
      $display("FAIL empty_no_beat got atualizar_seen=%b beats=%0d want 0 0", viu_atualizar, q_end.size());
    end
    checks++;
    if (q_addr.size() != 1 || ocupado_out !== 1'b0 || n_pronto != 1) begin
      errors++;
      $display("FAIL empty_busy_start got reads=%0d ocupado=%b pronto_pulses=%0d want 1 0 1",
               q_addr.size(), ocupado_out, n_pronto);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_two_neighbours();
    test_back_to_back_hold();
    test_four_slots();
    test_overflow();
    test_empty_list();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
